// File: rtl/rv32_data_mem_responder.sv
// rv32_data_mem_responder: data-memory responder with word RAM and an MMIO page holding a
// 64-bit cycle timer, a TX byte FIFO with valid/ready drain, status and drop-count registers.
module rv32_data_mem_responder #(
  parameter int          DEPTH      = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wen,
  output logic [31:0] mem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bad_access
);
  localparam int          AW        = $clog2(DEPTH);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  logic [31:0]   ram_q [DEPTH];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [63:0]   timer_q, timer_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FW:0]   cnt_q, cnt_d;
  logic [7:0]    drop_q, drop_d;
  logic          bad_q, bad_d;
  logic          ram_hit, mmio_hit, full, empty, pop, push_req, push, drop, drop_clr;
  logic [2:0]    off;
  logic [AW-1:0] idx;
  logic [31:0]   mmio_rdata;
  always_comb begin
    ram_hit    = mem_addr < RAM_BYTES;
    mmio_hit   = mem_addr[31:5] == MMIO_BASE[31:5];
    off        = mem_addr[4:2];
    idx        = mem_addr[AW+1:2];
    full       = cnt_q == (FW+1)'(FIFO_DEPTH);
    empty      = cnt_q == '0;
    pop        = !empty && tx_ready;
    push_req   = mmio_hit && off == 3'd2 && mem_wen[0];
    // a full FIFO still accepts a push when the head leaves in the same cycle
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    drop_clr   = mmio_hit && off == 3'd4 && |mem_wen;
    timer_d    = timer_q + 64'd1;
    wr_ptr_d   = push ? wr_ptr_q + FW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + FW'(1) : rd_ptr_q;
    cnt_d      = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
    drop_d     = drop_clr ? '0 : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    bad_d      = !ram_hit && !mmio_hit && |mem_wen;
    mmio_rdata = off == 3'd0 ? timer_q[31:0] :
                 off == 3'd1 ? timer_q[63:32] :
                 off == 3'd3 ? {16'b0, 8'(cnt_q), 6'b0, empty, full} :
                 off == 3'd4 ? {24'b0, drop_q} : '0;
    mem_rdata  = ram_hit ? ram_q[idx] : mmio_hit ? mmio_rdata : '0;
    tx_valid   = !empty;
    tx_data    = empty ? '0 : fifo_q[rd_ptr_q];
    bad_access = bad_q;
  end
  // storage arrays are not reset; emptiness is tracked by the pointers and count
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_hit && mem_wen[i]) ram_q[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (push) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      bad_q    <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      bad_q    <= bad_d;
    end
  end
endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// tb_rv32_data_mem_responder: scoreboard bench; a queue-based reference model predicts reads,
// the TX byte stream and bad_access, and a negedge monitor compares them against the DUT.
module tb_rv32_data_mem_responder;
  localparam logic [31:0] MB = 32'h1000_0000;
  localparam int          FD = 4;
  logic        clk = 0, rst = 1, tx_ready = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata;
  logic [3:0]  mem_wen = 0;
  logic        tx_valid, bad_access;
  logic [7:0]  tx_data;

  rv32_data_mem_responder dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .bad_access(bad_access)
  );

  always #5 clk = ~clk;

  logic [31:0] m_ram [int];
  logic [7:0]  m_fifo[$];
  logic [7:0]  tx_q[$];
  int          m_drop = 0;
  logic [63:0] m_timer = 0;
  logic        bad_exp = 0;
  logic [31:0] rd_q[$];
  logic [31:0] rd_a[$];
  logic        rd_chk = 0;
  int          n_cmp = 0, n_bad = 0;
  logic        mpop, mfull, mmio, mram;
  logic [31:0] mw;

  function automatic logic exp_read(input logic [31:0] a, output logic [31:0] v);
    v = 0;
    if (a < 32'd4096) begin
      if (!m_ram.exists(int'(a[11:2]))) return 0;
      v = m_ram[int'(a[11:2])];
    end else if (a[31:5] == MB[31:5]) begin
      case (a[4:2])
        3'd0: v = m_timer[31:0];
        3'd1: v = m_timer[63:32];
        3'd3: v = {16'b0, 8'(m_fifo.size()), 6'b0, m_fifo.size() == 0, m_fifo.size() == FD};
        3'd4: v = 32'(m_drop);
        default: v = 0;
      endcase
    end
    return 1;
  endfunction

  // reference model: state advances on each clock edge from the inputs of that cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_timer = 0;
      m_fifo.delete();
      tx_q.delete();
      m_drop  = 0;
      bad_exp = 0;
    end else begin
      mpop    = m_fifo.size() != 0 && tx_ready;
      mfull   = m_fifo.size() == FD;
      mmio    = mem_addr[31:5] == MB[31:5];
      mram    = mem_addr < 32'd4096;
      bad_exp = !mram && !mmio && mem_wen != 0;
      if (mram && mem_wen != 0) begin
        mw = m_ram.exists(int'(mem_addr[11:2])) ? m_ram[int'(mem_addr[11:2])] : 0;
        for (int i = 0; i < 4; i++) if (mem_wen[i]) mw[8*i +: 8] = mem_wdata[8*i +: 8];
        m_ram[int'(mem_addr[11:2])] = mw;
      end
      if (mpop) void'(m_fifo.pop_front());
      if (mmio && mem_addr[4:2] == 3'd2 && mem_wen[0]) begin
        if (!mfull || mpop) begin
          m_fifo.push_back(mem_wdata[7:0]);
          tx_q.push_back(mem_wdata[7:0]);
        end else if (m_drop < 255) m_drop++;
      end
      if (mmio && mem_addr[4:2] == 3'd4 && mem_wen != 0) m_drop = 0;
      m_timer++;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rd_chk) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL rdata: no expected value queued");
      end else begin
        logic [31:0] e, a;
        e = rd_q.pop_front();
        a = rd_a.pop_front();
        if (mem_rdata !== e) begin
          n_bad++;
          $display("FAIL rdata @%h: got %h want %h", a, mem_rdata, e);
        end
      end
    end
    n_cmp++;
    if (bad_access !== bad_exp) begin
      n_bad++;
      $display("FAIL bad_access: got %b want %b", bad_access, bad_exp);
    end
    n_cmp++;
    if (tx_valid !== (m_fifo.size() != 0)) begin
      n_bad++;
      $display("FAIL tx_valid: got %b want %b", tx_valid, m_fifo.size() != 0);
    end
    if (tx_valid && tx_ready) begin
      n_cmp++;
      if (tx_q.size() == 0) begin
        n_bad++;
        $display("FAIL tx_data: got %h with nothing expected", tx_data);
      end else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        if (tx_data !== e) begin
          n_bad++;
          $display("FAIL tx_data: got %h want %h", tx_data, e);
        end
      end
    end else if (!tx_valid) begin
      n_cmp++;
      if (tx_data !== 8'h00) begin
        n_bad++;
        $display("FAIL tx_data_idle: got %h want 00", tx_data);
      end
    end
  end

  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] e;
    mem_addr  = a;
    mem_wdata = d;
    mem_wen   = w;
    if (exp_read(a, e)) begin
      rd_q.push_back(e);
      rd_a.push_back(a);
      rd_chk = 1;
    end
    @(posedge clk);
    #1;
    rd_chk  = 0;
    mem_wen = 0;
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1;
    while (tx_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (tx_valid) begin
      n_bad++;
      $display("FAIL drain_timeout: tx_valid still %b after %0d cycles", tx_valid, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tx_valid %b", tx_valid);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    op(MB + 32'h0C, 0, 0);
    op(MB + 32'h00, 0, 0);
    rst = 0;
    op(MB + 32'h00, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    op(MB + 32'h00, 0, 0);
    op(MB + 32'h04, 0, 0);
    // RAM byte lanes and unmapped read
    op(32'h40, 32'hAABB_CCDD, 4'hF);
    op(32'h40, 32'h0000_1100, 4'b0010);
    op(32'h40, 0, 0);
    op(32'h2000_0000, 0, 0);
    // read-during-write returns the old word
    op(32'h40, 32'h1234_5678, 4'hF);
    op(32'h43, 0, 0);
    // FIFO ordering, full status and drop
    tx_ready = 0;
    for (int i = 0; i < 4; i++) op(MB + 32'h08, 32'h41 + i, 4'h1);
    op(MB + 32'h0C, 0, 0);
    op(MB + 32'h08, 32'h45, 4'h1);
    op(MB + 32'h10, 0, 0);
    op(MB + 32'h08, 32'h46, 4'hE);
    op(MB + 32'h08, 0, 0);
    drain();
    op(MB + 32'h0C, 0, 0);
    // full with simultaneous push and pop
    tx_ready = 0;
    for (int i = 0; i < 4; i++) op(MB + 32'h08, 32'h51 + i, 4'h1);
    tx_ready = 1;
    op(MB + 32'h08, 32'h55, 4'h1);
    op(MB + 32'h10, 0, 0);
    drain();
    // drop counter saturation and clear
    tx_ready = 0;
    for (int i = 0; i < 264; i++) op(MB + 32'h08, 32'(i), 4'h1);
    op(MB + 32'h10, 0, 0);
    op(MB + 32'h10, 32'hFFFF_FFFF, 4'h8);
    op(MB + 32'h10, 0, 0);
    drain();
    // unmapped writes pulse bad_access; reads and reserved MMIO do not
    op(32'h3000_0000, 32'hDEAD_BEEF, 4'hF);
    op(32'h3000_0000, 0, 0);
    op(32'h0000_1000, 32'h1, 4'h1);
    op(MB + 32'h20, 32'h1, 4'h2);
    op(MB + 32'h14, 32'hFFFF_FFFF, 4'hF);
    op(MB + 32'h14, 0, 0);
    op(32'h40, 0, 0);
    // timer low word wrap into high word
    force dut.timer_q = 64'h0000_0000_FFFF_FFFE;
    m_timer = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.timer_q;
    op(MB + 32'h00, 0, 0);
    op(MB + 32'h04, 0, 0);
    op(MB + 32'h04, 0, 0);
    op(MB + 32'h00, 0, 0);
    // reset mid-stream
    tx_ready = 0;
    for (int i = 0; i < 3; i++) op(MB + 32'h08, 32'h61 + i, 4'h1);
    rst = 1;
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_tx_valid: got %b want 0", tx_valid);
    end
    @(posedge clk);
    #1;
    rst = 0;
    op(MB + 32'h00, 0, 0);
    op(MB + 32'h0C, 0, 0);
    op(MB + 32'h10, 0, 0);
    // randomized traffic
    for (int i = 0; i < 16; i++) op(32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 500; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 8))
        0: op(32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
        1: op(32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)), 0, 0);
        2: op(MB + 32'h08, $urandom, 4'($urandom_range(0, 15)));
        3: op(MB + 32'h0C, 0, 0);
        4: op(MB + 32'h10, 0, 0);
        5: op(MB + 32'h10, $urandom, 4'($urandom_range(1, 15)));
        6: op(MB + 32'($urandom_range(0, 1)) * 4, 0, 0);
        7: op(32'h2000_0000 + 32'($urandom_range(0, 4095)), $urandom, 4'($urandom_range(0, 15)));
        default: op(MB + 32'($urandom_range(5, 7)) * 4, $urandom, 4'($urandom_range(0, 15)));
      endcase
    end
    drain();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL read_queue: %0d expected reads never compared, want 0", rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32_data_mem_responder.md
Name: rv32_data_mem_responder

Overview:
- Responder for the RV32I core's data-memory initiator port (addr, wdata, 4-bit byte write enables, rdata).
- Single-cycle core, so reads are combinational from address; writes commit on the clock edge.
- Decodes two regions:
  - word RAM at address 0.
  - MMIO page with a 64-bit free-running cycle timer, an output byte FIFO with valid/ready drain port, status and drop-count registers.
- Sits beside the core in the SoC top; the FIFO drain feeds a future UART transmitter or testbench console.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of 2; AW = clog2(DEPTH).
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, >= 2.
- MMIO_BASE, 32'h1000_0000, base of MMIO page; 32-byte aligned.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_addr  in  32  byte address from core
- mem_wdata  in  32  write data, lane-aligned by core
- mem_wen  in  4  byte write enables; bit i writes byte lane i; 0 = read/idle
- mem_rdata  out  32  combinational read data
- tx_valid  out  1  FIFO head valid
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  sink accepts head when tx_valid & tx_ready
- bad_access  out  1  registered one-cycle pulse: previous cycle wrote an unmapped address

Behaviour:
- Reset (async assert, sync-released by system):
  - timer=0, FIFO empty (rd/wr ptr=0, count=0), drop_cnt=0.
  - tx_valid=0, tx_data=0, bad_access=0.
  - RAM contents are not reset.
  - mem_rdata follows the address decode even during reset; MMIO reads return reset values.
- Decode:
  - RAM hit: mem_addr < DEPTH*4.
  - MMIO hit: mem_addr[31:5] == MMIO_BASE[31:5].
  - Everything else is unmapped.
  - mem_addr[1:0] is ignored everywhere (word access; core aligns lanes).
- RAM:
  - Index is mem_addr[AW+1:2].
  - Read is combinational from the array.
  - Write updates only the lanes with mem_wen set, at the clock edge.
  - Read-during-write returns the old word.
- MMIO map (offset):
  - 0x00 TIMER_LO: RO, timer[31:0].
  - 0x04 TIMER_HI: RO, timer[63:32].
    - Timer increments by 1 every cycle; wraps 2^64-1 -> 0.
    - No hi/lo snapshot.
  - 0x08 TX_DATA: WO.
    - A write with mem_wen[0]=1 pushes mem_wdata[7:0].
    - Writes with mem_wen[0]=0 are ignored.
    - Reads return 0.
  - 0x0C STATUS: RO.
    - bit0 = full, bit1 = empty, bits[15:8] = count, all other bits 0.
  - 0x10 DROP: RO, {24'b0, drop_cnt}.
    - Any write (mem_wen != 0) clears drop_cnt to 0.
  - 0x14-0x1C: reads 0, writes ignored (mapped, no bad_access).
  - All MMIO reads reflect pre-edge state.
- Unmapped access:
  - Read returns 32'h0.
  - A write with mem_wen != 0 is ignored and sets bad_access=1 for exactly the next cycle.
- FIFO:
  - tx_valid = !empty; tx_data = head entry, or 0 when empty.
  - pop = tx_valid & tx_ready.
  - Push when not full: entry is written, wr_ptr+1 (wraps).
  - Push when full without pop: byte dropped; drop_cnt+1, saturating at 255.
  - Push when full with simultaneous pop: both accepted, count unchanged, no drop.
  - Push when empty: tx_valid rises on the next cycle (no fall-through).
  - Pop when empty: impossible by construction.
  - Clearing DROP and a drop in the same cycle: the clear wins, drop_cnt=0.
- Latency:
  - Read: 0 cycles.
  - Write: visible 1 cycle later.
  - TX_DATA write to tx_valid: 1 cycle.
- Reset mid-operation: FIFO contents discarded immediately (tx_valid falls asynchronously); timer restarts at 0.

Test Plan:
- RAM byte enables: write 0xAABBCCDD to 0x40 with wen=4'hF, then 0x11 with wen=4'b0010 -> read 0x40 = 0xAABB11DD; read 0x44 before any write at an unmapped address 0x2000_0000 returns 0.
- Timer: release reset, read TIMER_LO at cycle N after release -> value N (±0 per defined edge); force timer to 0xFFFF_FFFF low via 2^32 cycles (or a forced bench preload) -> HI increments, LO wraps to 0.
- FIFO ordering/backpressure: tx_ready=0, write bytes 0x41,0x42,0x43,0x44 -> STATUS=0x0000_0401 (count 4, full); 5th write 0x45 -> DROP=1; raise tx_ready -> tx_data sequence 0x41..0x44, then tx_valid=0, STATUS=0x0000_0002.
- Full + simultaneous push/pop: FIFO full, tx_ready=1 while writing 0x55 -> count stays 4, DROP unchanged, 0x55 emerges 4th.
- Unmapped write: wen=4'hF to 0x3000_0000 -> bad_access high exactly one cycle later, no RAM/MMIO change; a read of the same address gives no pulse.
- Reset mid-stream: assert rst with 3 bytes queued -> tx_valid=0 immediately, STATUS=0x2, DROP=0, TIMER_LO=0 after release.
